counter_bank: RTL and testbench

Parametrised bank of independent programmable counters. It replaces single free-running wrap counters wherever the design needs several of them. Each channel supports count enable, up/down direction, a programmable terminal limit, wrap or saturate mode, synchronous parallel load and a sticky overflow flag. Status and counts are fully registered.

---
 rtl/counter_bank.sv | 94 +++++++++
 tb/tb_counter_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - parametrised bank of independent programmable counters
//
// Purpose: `channels` independent counters. Each channel has count enable,
// up/down direction, a programmable terminal limit, wrap or saturate mode,
// synchronous parallel load and a sticky terminal-event flag. All outputs
// are registered.
//
// Ports (channel c occupies bits [c*width +: width] of each packed bus):
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset, clears all state
//   i_en           per-channel count enable
//   i_down         per-channel direction (0 up, 1 down)
//   i_sat          per-channel mode (0 wrap, 1 saturate)
//   i_load         per-channel synchronous load strobe (beats i_en)
//   i_load_value   per-channel load value
//   i_limit        per-channel terminal value
//   i_clr_sticky   per-channel sticky-flag clear
//   o_count        per-channel registered count
//   o_wrap         per-channel one-cycle terminal-event pulse
//   o_sticky       per-channel sticky terminal-event flag

module counter_bank #(
  parameter int width    = 32,
  parameter int channels = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [channels-1:0]         i_en,
  input  logic [channels-1:0]         i_down,
  input  logic [channels-1:0]         i_sat,
  input  logic [channels-1:0]         i_load,
  input  logic [channels*width-1:0]   i_load_value,
  input  logic [channels*width-1:0]   i_limit,
  input  logic [channels-1:0]         i_clr_sticky,
  output logic [channels*width-1:0]   o_count,
  output logic [channels-1:0]         o_wrap,
  output logic [channels-1:0]         o_sticky
);

  for (genvar c = 0; c < channels; c++) begin : g_ch
    logic [width-1:0] count_q, count_d;
    logic [width-1:0] limit;
    logic [width-1:0] load_value;
    logic             wrap_q, wrap_d;
    logic             sticky_q, sticky_d;
    logic             terminal;
    logic             term_event;

    assign limit      = i_limit[c*width +: width];
    assign load_value = i_load_value[c*width +: width];

    // Up uses >= so a loaded or limit-lowered count above the limit is
    // caught on the next enabled cycle rather than running to rollover.
    assign terminal   = i_down[c] ? (count_q == '0) : (count_q >= limit);
    assign term_event = i_en[c] && !i_load[c] && terminal;

    always_comb begin
      count_d = count_q;
      if (i_load[c]) begin
        count_d = load_value;
      end else if (i_en[c]) begin
        if (!terminal) begin
          count_d = i_down[c] ? count_q - 1'b1 : count_q + 1'b1;
        end else if (i_sat[c]) begin
          // Saturate: up clamps to limit, down stays at zero.
          count_d = i_down[c] ? '0 : limit;
        end else begin
          count_d = i_down[c] ? limit : '0;
        end
      end
    end

    assign wrap_d   = term_event;
    // A set in the same cycle as a clear wins.
    assign sticky_d = term_event || (sticky_q && !i_clr_sticky[c]);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        count_q  <= '0;
        wrap_q   <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        count_q  <= count_d;
        wrap_q   <= wrap_d;
        sticky_q <= sticky_d;
      end
    end

    assign o_count[c*width +: width] = count_q;
    assign o_wrap[c]                 = wrap_q;
    assign o_sticky[c]               = sticky_q;
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - self-checking bench for counter_bank

module tb_counter_bank;

  localparam int W = 8;
  localparam int C = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [C-1:0]     i_en, i_down, i_sat, i_load, i_clr_sticky;
  logic [C*W-1:0]   i_load_value, i_limit;
  logic [C*W-1:0]   o_count;
  logic [C-1:0]     o_wrap, o_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string          tag;
    logic [C*W-1:0] cnt;
    logic [C-1:0]   wrap;
    logic [C-1:0]   sticky;
  } exp_t;

  exp_t sb[$];

  int m_cnt[C];
  bit m_wrap[C];
  bit m_sticky[C];

  int exp_up[5]   = '{1, 2, 3, 0, 1};
  int exp_upw[5]  = '{0, 0, 0, 1, 0};
  int exp_ups[5]  = '{0, 0, 0, 1, 1};

  counter_bank #(.width(W), .channels(C)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_down       (i_down),
    .i_sat        (i_sat),
    .i_load       (i_load),
    .i_load_value (i_load_value),
    .i_limit      (i_limit),
    .i_clr_sticky (i_clr_sticky),
    .o_count      (o_count),
    .o_wrap       (o_wrap),
    .o_sticky     (o_sticky)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] cnt(input int c);
    return 32'(o_count[c*W +: W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      m_cnt[c]    = 0;
      m_wrap[c]   = 1'b0;
      m_sticky[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < C; c++) begin
      int lim;
      int nxt;
      bit evt;
      lim = int'(i_limit[c*W +: W]);
      nxt = m_cnt[c];
      evt = 1'b0;
      if (i_load[c]) begin
        nxt = int'(i_load_value[c*W +: W]);
      end else if (i_en[c]) begin
        if (i_down[c]) begin
          if (m_cnt[c] == 0) begin
            evt = 1'b1;
            nxt = i_sat[c] ? 0 : lim;
          end else begin
            nxt = m_cnt[c] - 1;
          end
        end else begin
          if (m_cnt[c] >= lim) begin
            evt = 1'b1;
            nxt = i_sat[c] ? lim : 0;
          end else begin
            nxt = m_cnt[c] + 1;
          end
        end
      end
      m_cnt[c]    = nxt;
      m_wrap[c]   = evt;
      m_sticky[c] = evt || (m_sticky[c] && !i_clr_sticky[c]);
    end
  endtask

  // Drive is already applied; predict, push, clock, then pop and compare.
  task automatic tick(input string tag);
    exp_t e;
    model_step();
    e.tag = tag;
    for (int c = 0; c < C; c++) begin
      e.cnt[c*W +: W] = W'(m_cnt[c]);
      e.wrap[c]       = m_wrap[c];
      e.sticky[c]     = m_sticky[c];
    end
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    for (int c = 0; c < C; c++) begin
      chk($sformatf("%s.sb_cnt%0d", e.tag, c), cnt(c), 32'(e.cnt[c*W +: W]));
      chk($sformatf("%s.sb_wrap%0d", e.tag, c), 32'(o_wrap[c]), 32'(e.wrap[c]));
      chk($sformatf("%s.sb_sticky%0d", e.tag, c), 32'(o_sticky[c]), 32'(e.sticky[c]));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("%s.cnt%0d", tag, c), cnt(c), 32'd0);
      chk($sformatf("%s.wrap%0d", tag, c), 32'(o_wrap[c]), 32'd0);
      chk($sformatf("%s.sticky%0d", tag, c), 32'(o_sticky[c]), 32'd0);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_en = '0; i_down = '0; i_sat = '0; i_load = '0; i_clr_sticky = '0;
    i_load_value = '0; i_limit = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Up-wrap on ch0, limit 3
    i_limit[0*W +: W] = 8'd3;
    i_en[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick("upwrap");
      chk("upwrap.cnt", cnt(0), 32'(exp_up[k]));
      chk("upwrap.wrap", 32'(o_wrap[0]), 32'(exp_upw[k]));
      chk("upwrap.sticky", 32'(o_sticky[0]), 32'(exp_ups[k]));
    end
    i_en[0] = 1'b0;

    // Down-wrap on ch1, limit 5, load 1 first
    i_limit[1*W +: W] = 8'd5;
    i_down[1] = 1'b1;
    i_load[1] = 1'b1;
    i_load_value[1*W +: W] = 8'd1;
    tick("dn_load");
    chk("dn_load.cnt", cnt(1), 32'd1);
    i_load[1] = 1'b0;
    i_en[1] = 1'b1;
    tick("dn_0");
    chk("dn_0.cnt", cnt(1), 32'd0);
    chk("dn_0.wrap", 32'(o_wrap[1]), 32'd0);
    tick("dn_5");
    chk("dn_5.cnt", cnt(1), 32'd5);
    chk("dn_5.wrap", 32'(o_wrap[1]), 32'd1);
    tick("dn_4");
    chk("dn_4.cnt", cnt(1), 32'd4);
    chk("dn_4.wrap", 32'(o_wrap[1]), 32'd0);

    // Down saturate from 0
    i_en[1] = 1'b0;
    i_load[1] = 1'b1;
    i_load_value[1*W +: W] = 8'd0;
    tick("dnsat_load");
    i_load[1] = 1'b0;
    i_sat[1] = 1'b1;
    i_en[1] = 1'b1;
    repeat (3) begin
      tick("dnsat");
      chk("dnsat.cnt", cnt(1), 32'd0);
      chk("dnsat.wrap", 32'(o_wrap[1]), 32'd1);
    end
    i_en[1] = 1'b0;

    // Load priority and overrange on ch2
    i_limit[2*W +: W] = 8'd10;
    i_sat[2] = 1'b1;
    i_load[2] = 1'b1;
    i_en[2] = 1'b1;
    i_load_value[2*W +: W] = 8'd200;
    tick("ld_over");
    chk("ld_over.cnt", cnt(2), 32'd200);
    chk("ld_over.wrap", 32'(o_wrap[2]), 32'd0);
    chk("ld_over.sticky", 32'(o_sticky[2]), 32'd0);
    i_load[2] = 1'b0;
    tick("ld_clamp");
    chk("ld_clamp.cnt", cnt(2), 32'd10);
    chk("ld_clamp.wrap", 32'(o_wrap[2]), 32'd1);

    // Sticky set/clear collision, then clear alone
    i_clr_sticky[2] = 1'b1;
    tick("stk_coll");
    chk("stk_coll.sticky", 32'(o_sticky[2]), 32'd1);
    chk("stk_coll.wrap", 32'(o_wrap[2]), 32'd1);
    i_en[2] = 1'b0;
    tick("stk_clr");
    chk("stk_clr.sticky", 32'(o_sticky[2]), 32'd0);
    chk("stk_clr.wrap", 32'(o_wrap[2]), 32'd0);
    i_clr_sticky[2] = 1'b0;

    // Reset mid-operation on ch0 at count 7
    i_limit[0*W +: W] = 8'd20;
    i_load[0] = 1'b1;
    i_load_value[0*W +: W] = 8'd5;
    tick("rst_ld");
    i_load[0] = 1'b0;
    i_en[0] = 1'b1;
    tick("rst_6");
    tick("rst_7");
    chk("rst_7.cnt", cnt(0), 32'd7);
    i_rst = 1'b1;
    #1;
    model_reset();
    sb.delete();
    chk_all_zero("rst_async");
    @(posedge i_clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge i_clk);
    i_rst = 1'b0;
    tick("rst_r1");
    chk("rst_r1.cnt", cnt(0), 32'd1);
    tick("rst_r2");
    chk("rst_r2.cnt", cnt(0), 32'd2);

    // limit=0 on ch3 while ch0 keeps counting
    i_limit[3*W +: W] = 8'd0;
    i_en[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick("lim0");
      chk("lim0.cnt3", cnt(3), 32'd0);
      chk("lim0.wrap3", 32'(o_wrap[3]), 32'd1);
      chk("lim0.cnt0", cnt(0), 32'(3 + k));
      chk("lim0.wrap0", 32'(o_wrap[0]), 32'd0);
      chk("lim0.sticky0", 32'(o_sticky[0]), 32'd0);
    end
    i_down[3] = 1'b1;
    tick("lim0_dn");
    chk("lim0_dn.cnt3", cnt(3), 32'd0);
    chk("lim0_dn.wrap3", 32'(o_wrap[3]), 32'd1);
    i_en[3] = 1'b0;

    // Limit lowered below current count on ch0 (count 6)
    i_limit[0*W +: W] = 8'd2;
    tick("lim_low");
    chk("lim_low.cnt", cnt(0), 32'd0);
    chk("lim_low.wrap", 32'(o_wrap[0]), 32'd1);
    chk("lim_low.sticky", 32'(o_sticky[0]), 32'd1);
    i_en[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
